// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester arbiter/sequencer for a single bidirectional-port
//               synchronous memory. Optional macro MEMARB_FIXED_PRIO_EN selects
//               fixed A-over-B priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_ack,
  output logic [DWIDTH-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_ack,
  output logic [DWIDTH-1:0] b_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  inout  wire  [DWIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                winner_q, winner_d;   // 0 = A, 1 = B
  logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wr_q, mem_wr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                drive_q, drive_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DWIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic [DWIDTH-1:0]   b_rdata_q, b_rdata_d;
  logic                grant_b;

`ifndef MEMARB_FIXED_PRIO_EN
  logic                prefer_b_q, prefer_b_d;
`endif

  always_comb begin
`ifdef MEMARB_FIXED_PRIO_EN
    grant_b = b_req & ~a_req;
`else
    grant_b = b_req & (~a_req | prefer_b_q);
`endif
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    mem_addr_d = mem_addr_q;
    mem_wr_d   = mem_wr_q;
    mem_rd_d   = mem_rd_q;
    drive_d    = drive_q;
    wdata_d    = wdata_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
`ifndef MEMARB_FIXED_PRIO_EN
    prefer_b_d = prefer_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          winner_d   = grant_b;
          mem_addr_d = grant_b ? b_addr  : a_addr;
          wdata_d    = grant_b ? b_wdata : a_wdata;
          mem_wr_d   = grant_b ? b_we    : a_we;
          mem_rd_d   = grant_b ? ~b_we   : ~a_we;
          drive_d    = grant_b ? b_we    : a_we;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is captured on the same edge that releases the port.
        if (mem_rd_q) begin
          if (winner_q) b_rdata_d = mem_data;
          else          a_rdata_d = mem_data;
        end
        mem_wr_d = 1'b0;
        mem_rd_d = 1'b0;
        drive_d  = 1'b0;
        a_ack_d  = ~winner_q;
        b_ack_d  = winner_q;
        state_d  = RESP;
      end
      RESP: begin
`ifndef MEMARB_FIXED_PRIO_EN
        prefer_b_d = ~winner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
      prefer_b_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
`ifndef MEMARB_FIXED_PRIO_EN
      prefer_b_q <= prefer_b_d;
`endif
    end
  end

  assign mem_data = drive_q ? wdata_q : {DWIDTH{1'bz}};
  assign mem_addr = mem_addr_q;
  assign mem_wr   = mem_wr_q;
  assign mem_rd   = mem_rd_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a behavioural
//               single-port memory on the tristate bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic [4:0] mem_addr;
  logic       mem_wr, mem_rd;
  wire  [7:0] mem_data;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];

  typedef struct {
    logic       is_b;
    logic [7:0] a_rd;
    logic [7:0] b_rd;
    int         gap;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ack = 0;
  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;

  mem_port_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory: drives the bus only while read-enabled, commits writes on the edge.
  assign mem_data = mem_rd ? mem[mem_addr] : 8'bz;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_data;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks bus invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr || mem_rd) chk("wr_rd_exclusive", {31'd0, mem_wr && mem_rd}, 32'd0);
      if (a_ack || b_ack) begin
        chk("ack_exclusive", {31'd0, a_ack && b_ack}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual a_ack=%0b b_ack=%0b required none", a_ack, b_ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_owner_b", {31'd0, b_ack}, {31'd0, e.is_b});
          chk("a_rdata", {24'd0, a_rdata}, {24'd0, e.a_rd});
          chk("b_rdata", {24'd0, b_rdata}, {24'd0, e.b_rd});
          if (e.gap != 0) chk("ack_gap", cyc - last_ack, e.gap);
        end
        last_ack = cyc;
      end
    end
  end

  task automatic single(input bit is_b, input bit we, input logic [4:0] addr, input logic [7:0] wd);
    exp_t e;
    int n;
    if (we) ref_mem[addr] = wd;
    else if (is_b) exp_b = ref_mem[addr];
    else exp_a = ref_mem[addr];
    e.is_b = is_b; e.a_rd = exp_a; e.b_rd = exp_b; e.gap = 0;
    sb.push_back(e);
    @(negedge clk);
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        chk("access_ctrl", {30'd0, mem_wr, mem_rd}, we ? 32'd2 : 32'd1);
        chk("access_addr", {27'd0, mem_addr}, {27'd0, addr});
      end
    end while (!(is_b ? b_ack : a_ack) && n < 8);
    chk("latency", n, 2);
    @(negedge clk);
    if (is_b) b_req = 0; else a_req = 0;
    @(posedge clk);
  endtask

  initial begin
    bit ord [6];
    int ac, bc, n;
`ifdef MEMARB_FIXED_PRIO_EN
    ord = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    ord = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {a_ack, b_ack, mem_wr, mem_rd, mem_addr, a_rdata, b_rdata}, 32'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk);

    single(0, 1, 5'h05, 8'hA5);
    single(0, 0, 5'h05, 8'h5A);
    single(0, 1, 5'h1F, 8'h3C);
    single(1, 0, 5'h1F, 8'h5A);

    // Both requesters hold req; each drops after its third ack.
    ref_mem[1] = 8'h11;
    ref_mem[2] = 8'h22;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.is_b = ord[i]; e.a_rd = exp_a; e.b_rd = exp_b; e.gap = (i == 0) ? 0 : 3;
      sb.push_back(e);
    end
    @(negedge clk);
    a_we = 1; a_addr = 5'h01; a_wdata = 8'h11;
    b_we = 1; b_addr = 5'h02; b_wdata = 8'h22;
    a_req = 1; b_req = 1;
    ac = 0; bc = 0; n = 0;
    while ((ac < 3 || bc < 3) && n < 60) begin
      @(negedge clk); n++;
      if (a_ack) begin ac++; if (ac == 3) a_req = 0; end
      if (b_ack) begin bc++; if (bc == 3) b_req = 0; end
    end
    chk("contend_a_acks", ac, 3);
    chk("contend_b_acks", bc, 3);
    a_req = 0; b_req = 0;
    @(posedge clk);
    single(0, 0, 5'h01, 8'h5A);
    single(1, 0, 5'h02, 8'h5A);

    // Reset in the middle of a write ACCESS: write must not commit.
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 5'h07; a_wdata = 8'hFF;
    @(posedge clk); #1;
    chk("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mid_outputs", {a_ack, b_ack, mem_rd, mem_addr, a_rdata, b_rdata}, 32'd0);
    a_req = 0;
    exp_a = 8'h00; exp_b = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    single(0, 0, 5'h07, 8'h5A);

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
